// File: rtl/mac_seq_bs.sv
// Bit-serial multiply sequencer: serializes a signed activation MSB-first and emits
// sign-correct partial products plus en/clr/mac_done for a downstream shift-add accumulator.
module mac_seq_bs #(
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned WWIDTH = 8,
  parameter int unsigned OWIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] ifm,
  input  logic [WWIDTH-1:0] wght,
  input  logic              sum_i_valid,
  output logic [OWIDTH-1:0] prod,
  output logic              en,
  output logic              clr,
  output logic              mac_done,
  output logic              sum_valid
);

  localparam int unsigned CntW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  localparam logic [CntW-1:0] CntMsb = CntW'(IWIDTH - 1);

  typedef enum logic [2:0] {StIdle, StClr, StShift, StWaitSum, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cnt_nxt;
  logic [IWIDTH-1:0]   act_q;
  logic [WWIDTH-1:0]   wght_q;
  logic [OWIDTH-1:0]   wght_ext;
  logic [OWIDTH-1:0]   wght_neg;

  // Negation happens after sign extension so the most negative weight cannot overflow.
  assign wght_ext = OWIDTH'($signed(wght_q));
  assign wght_neg = OWIDTH'(0) - wght_ext;
  assign cnt_nxt  = cnt_q - CntW'(1);
  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      act_q     <= '0;
      wght_q    <= '0;
      prod      <= '0;
      en        <= 1'b0;
      clr       <= 1'b0;
      mac_done  <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      prod      <= '0;
      en        <= 1'b0;
      clr       <= 1'b0;
      mac_done  <= 1'b0;
      sum_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            act_q   <= ifm;
            wght_q  <= wght;
            clr     <= 1'b1;
            state_q <= StClr;
          end
        end
        StClr: begin
          cnt_q   <= CntMsb;
          en      <= 1'b1;
          prod    <= act_q[IWIDTH-1] ? wght_neg : '0;
          state_q <= StShift;
        end
        StShift: begin
          if (cnt_q == '0) begin
            if (sum_i_valid) begin
              en       <= 1'b1;
              mac_done <= 1'b1;
              state_q  <= StDone;
            end else begin
              state_q  <= StWaitSum;
            end
          end else begin
            cnt_q <= cnt_nxt;
            en    <= 1'b1;
            prod  <= act_q[cnt_nxt] ? wght_ext : '0;
          end
        end
        StWaitSum: begin
          if (sum_i_valid) begin
            en       <= 1'b1;
            mac_done <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          sum_valid <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_bs.sv
// Self-checking bench for mac_seq_bs: drives operand pairs, models the downstream
// shift-add accumulator, and checks control timing, partial products and results.
module tb_mac_seq_bs;

  localparam int IW = 8;
  localparam int WW = 8;
  localparam int OW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] ifm;
  logic [WW-1:0] wght;
  logic          sum_i_valid;
  logic [OW-1:0] prod;
  logic          en;
  logic          clr;
  logic          mac_done;
  logic          sum_valid;

  logic [OW-1:0] sum_i_val;
  logic [OW-1:0] acc;

  int n_checks = 0;
  int n_errors = 0;

  mac_seq_bs #(.IWIDTH(IW), .WWIDTH(WW), .OWIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ifm        (ifm),
    .wght       (wght),
    .sum_i_valid(sum_i_valid),
    .prod       (prod),
    .en         (en),
    .clr        (clr),
    .mac_done   (mac_done),
    .sum_valid  (sum_valid)
  );

  always #5 clk = ~clk;

  // Downstream accumulator: MSB-first shift-add, adds sum_i when mac_done.
  always @(posedge clk or posedge rst) begin
    if (rst)           acc <= '0;
    else if (clr)      acc <= '0;
    else if (en)       acc <= mac_done ? acc + sum_i_val : (acc << 1) + prod;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation starting from an IDLE cycle; ends in the sum_valid cycle.
  task automatic do_op(input int a, input int w, input int si, input int stall, input bit keep);
    logic [IW-1:0] ab;
    int exp_p;
    int cycles;
    ab = IW'(a);
    check_eq("ready_before", int'(in_ready), 1);
    ifm         = IW'(a);
    wght        = WW'(w);
    sum_i_val   = OW'(si);
    sum_i_valid = (stall == 0);
    in_valid    = 1'b1;
    tick();
    cycles = 0;
    if (!keep) in_valid = 1'b0;
    // Operands must be ignored after the transfer edge.
    ifm  = IW'($urandom);
    wght = WW'($urandom);
    check_eq("clr_cycle_clr", int'(clr), 1);
    check_eq("clr_cycle_en", int'(en), 0);
    check_eq("clr_cycle_prod", int'($signed(prod)), 0);
    check_eq("busy_ready", int'(in_ready), 0);
    for (int k = IW - 1; k >= 0; k--) begin
      tick();
      cycles++;
      if (ab[k]) exp_p = (k == IW - 1) ? -w : w;
      else       exp_p = 0;
      check_eq("shift_en", int'(en), 1);
      check_eq("shift_prod", int'($signed(prod)), exp_p);
      check_eq("shift_done", int'(mac_done), 0);
      check_eq("shift_clr", int'(clr), 0);
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      cycles++;
      check_eq("wait_en", int'(en), 0);
      check_eq("wait_prod", int'($signed(prod)), 0);
      check_eq("wait_ready", int'(in_ready), 0);
      if (s == stall - 1) sum_i_valid = 1'b1;
    end
    tick();
    cycles++;
    check_eq("done_en", int'(en), 1);
    check_eq("done_mac_done", int'(mac_done), 1);
    check_eq("done_prod", int'($signed(prod)), 0);
    check_eq("done_sum_valid", int'(sum_valid), 0);
    tick();
    cycles++;
    check_eq("sum_valid", int'(sum_valid), 1);
    check_eq("result", int'($signed(acc)), si + a * w);
    check_eq("latency", cycles + 1, IW + 3 + stall);
    check_eq("final_ready", int'(in_ready), 1);
    check_eq("final_en", int'(en), 0);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    tick();
    check_eq("idle_sum_valid", int'(sum_valid), 0);
    check_eq("idle_ready", int'(in_ready), 1);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b1;
    ifm         = 8'd3;
    wght        = 8'd5;
    sum_i_valid = 1'b0;
    sum_i_val   = '0;
    #1;
    check_eq("rst_ready", int'(in_ready), 1);
    check_eq("rst_prod", int'(prod), 0);
    check_eq("rst_ctrl", int'({en, clr, mac_done, sum_valid}), 0);
    tick();
    tick();
    check_eq("rst_no_xfer_clr", int'(clr), 0);
    check_eq("rst_no_xfer_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check_eq("post_rst_clr", int'(clr), 0);

    do_op(3, 5, 0, 0, 1'b0);
    idle_cycle();
    do_op(-1, 7, 0, 0, 1'b0);
    idle_cycle();
    do_op(-128, -128, 100, 0, 1'b0);
    idle_cycle();
    do_op(-37, 91, -250, 3, 1'b0);
    idle_cycle();

    // Reset during the 4th SHIFT cycle.
    ifm         = 8'd100;
    wght        = 8'd77;
    sum_i_valid = 1'b1;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("pre_rst_en", int'(en), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_prod", int'(prod), 0);
    check_eq("arst_ctrl", int'({en, clr, mac_done, sum_valid}), 0);
    check_eq("arst_ready", int'(in_ready), 1);
    tick();
    #2 rst = 1'b0;
    tick();
    for (int i = 0; i < IW + 4; i++) begin
      check_eq("post_arst_sum_valid", int'(sum_valid), 0);
      check_eq("post_arst_ready", int'(in_ready), 1);
      tick();
    end
    do_op(2, -3, 0, 0, 1'b0);
    idle_cycle();

    // Back-to-back with in_valid held high.
    do_op(2, 3, 0, 0, 1'b1);
    do_op(-4, 5, 0, 0, 1'b0);
    idle_cycle();

    for (int r = 0; r < 20; r++) begin
      do_op($signed(8'($urandom)), $signed(8'($urandom)), int'($urandom_range(0, 2000)) - 1000,
            int'($urandom_range(0, 3)), 1'(r % 2));
      if (r % 2 == 0) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_seq_bs.md
Name: mac_seq_bs

Overview:
Bit-serial multiply sequencer sitting directly upstream of the binary-serial accumulator in each 8-bit PE. It accepts one signed activation/weight pair per operation and serializes the activation MSB-first. Each cycle it emits a sign-correct partial product plus the en/clr/mac_done controls, so the downstream shift-add accumulator forms sum_i + act*wght. It also flags when the accumulated result is valid.

Parameters:
IWIDTH, 8, activation width in bits; sets the number of serial cycles.
WWIDTH, 8, weight width in bits.
OWIDTH, 24, partial-product and accumulator width in bits.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  sequencer can accept a pair; combinational decode of IDLE.
ifm  input  IWIDTH  signed activation.
wght  input  WWIDTH  signed weight.
sum_i_valid  input  1  upstream partial sum on the accumulator's sum_i is valid.
prod  output  OWIDTH  signed partial product to the accumulator.
en  output  1  accumulator enable.
clr  output  1  accumulator clear.
mac_done  output  1  accumulator selects sum_i + sum_o.
sum_valid  output  1  one-cycle pulse: the accumulator's sum_o holds the final result.

Behaviour:
- Reset (async, active-high):
  - State is IDLE.
  - prod, en, clr, mac_done and sum_valid are 0.
  - The bit counter is 0.
  - in_ready reads 1 in IDLE, including while rst is high, but no transfer occurs while rst is high.
- Transfer: in_valid & in_ready at a rising edge. ifm and wght are latched into internal registers at that edge.
- All outputs except in_ready are registered.
- States: IDLE, CLR, SHIFT, WAIT_SUM, DONE.
  - IDLE: all controls 0. On transfer, go to CLR.
  - CLR: one cycle. clr=1, en=0, prod=0. Next state is SHIFT with counter = IWIDTH-1.
  - SHIFT: IWIDTH cycles, en=1, mac_done=0, counter decrements each cycle. Bit b = act[counter].
    - Counter == IWIDTH-1 (sign bit): prod = -sext(wght) if b=1, else 0.
    - Other bits: prod = sext(wght) if b=1, else 0.
    - After counter 0: if sum_i_valid is high in that cycle, go to DONE; otherwise go to WAIT_SUM.
  - WAIT_SUM: en=0, prod=0. Accumulator holds. Stay until sum_i_valid=1, then go to DONE.
  - DONE: one cycle, en=1, mac_done=1, prod=0. Next state is IDLE. sum_valid=1 in the following cycle (the first IDLE cycle).
- Timing: transfer at edge T gives clr in cycle T+1, SHIFT in T+2..T+IWIDTH+1, and DONE at T+IWIDTH+2 with no stall. sum_valid pulses at T+IWIDTH+3.
- in_ready is 0 from CLR through DONE.
- Back-to-back: with in_valid held high, the next transfer occurs in the sum_valid cycle. Initiation interval is IWIDTH+3 cycles with no stall.
- Arithmetic: prod is the sign extension of wght to OWIDTH; negation is performed in OWIDTH bits, so wght = -2^(WWIDTH-1) negates without overflow. The accumulator's MSB-first shift-add then yields sum_i + ifm*wght exactly.
- Operands are ignored except at a transfer edge. Changes on ifm/wght mid-operation have no effect.
- sum_i_valid is ignored outside SHIFT (last cycle) and WAIT_SUM.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The partial operation is discarded and no sum_valid is issued.

Test Plan:
- ifm=3, wght=5, sum_i=0, sum_i_valid=1: prod sequence 0,0,0,0,0,0,5,5, then DONE. Accumulator result 15; sum_valid pulse at T+11.
- ifm=-1 (0xFF), wght=7, sum_i=0: prod sequence -7 then +7 x7. Result -7.
- ifm=-128, wght=-128, sum_i=100: first prod +128, the rest 0. Result 16484, with no overflow at OWIDTH=24.
- sum_i_valid held low for 3 cycles after SHIFT: en=0 for 3 WAIT_SUM cycles, accumulator holds, DONE follows sum_i_valid rising, and sum_valid is delayed by 3 cycles.
- rst pulsed during the 4th SHIFT cycle: all outputs 0 asynchronously, in_ready=1 after release, no sum_valid; the next pair ifm=2, wght=-3 gives -6.
- in_valid held high with two pairs (2,3) then (-4,5): second transfer in the sum_valid cycle, clr precedes the second SHIFT, results 6 then -20, 11 cycles apart.
